// File: rtl/byte_frame_serializer.sv
//------------------------------------------------------------------------------
// byte_frame_serializer
//   Buffers bytes in a small FIFO and sends each as a UART-style frame on tx
//   (start 0, 8 data bits LSB first, stop 1); bytes offered while full are
//   counted in a saturating drop counter.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module byte_frame_serializer #(
  parameter int FIFO_DEPTH   = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic [7:0] drop_cnt
);

  localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_cnt_w = $clog2(FIFO_DEPTH) + 1;
  localparam int c_bit_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(FIFO_DEPTH);
  localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t             r_state;
  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic [c_bit_w-1:0] r_bit_cnt;
  logic [2:0]         r_idx;
  logic [7:0]         r_sh;
  logic               r_tx;
  logic               r_busy;
  logic [7:0]         r_drop_cnt;

  logic               w_push;
  logic               w_pop;
  logic               w_bit_end;
  logic [7:0]         w_rd_data;

  // in_ready comes from the registered count only, so a pop on a full
  // FIFO frees a slot no earlier than the following cycle.
  assign in_ready  = (r_count != c_depth);
  assign w_push    = in_valid && in_ready;
  assign w_bit_end = (r_bit_cnt == c_bit_last);
  assign w_rd_data = r_mem[r_rd_ptr];
  assign w_pop     = (r_count != '0) &&
                     ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));

  assign tx       = r_tx;
  assign busy     = r_busy;
  assign drop_cnt = r_drop_cnt;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
      if (in_valid && !in_ready && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_bit_cnt <= '0;
      r_idx     <= '0;
      r_sh      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_bit_cnt <= '0;
          if (w_pop) begin
            r_sh    <= w_rd_data;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_START;
          end else begin
            r_tx <= 1'b1;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            r_tx      <= r_sh[0];
            r_idx     <= '0;
            r_state   <= S_DATA;
          end else begin
            r_bit_cnt <= r_bit_cnt + c_bit_w'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            if (r_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_sh  <= {1'b0, r_sh[7:1]};
              r_tx  <= r_sh[1];
              r_idx <= r_idx + 3'd1;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + c_bit_w'(1);
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            // A queued byte starts its frame straight after this stop bit.
            if (w_pop) begin
              r_sh    <= w_rd_data;
              r_tx    <= 1'b0;
              r_state <= S_START;
            end else begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + c_bit_w'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_byte_frame_serializer.sv
//------------------------------------------------------------------------------
// tb_byte_frame_serializer
//   Directed bench for byte_frame_serializer at CLKS_PER_BIT=4 and =1.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_byte_frame_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic [7:0] drop_cnt;

  logic       v1 = 1'b0;
  logic [7:0] d1 = 8'h00;
  logic       rdy1;
  logic       tx1;
  logic       busy1;
  logic [7:0] drop1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  byte_frame_serializer #(.FIFO_DEPTH(4), .CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .tx(tx), .busy(busy), .drop_cnt(drop_cnt)
  );

  byte_frame_serializer #(.FIFO_DEPTH(4), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_data(d1),
    .in_ready(rdy1), .tx(tx1), .busy(busy1), .drop_cnt(drop1)
  );

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Frame bit b (0=start, 1..8=data LSB first, 9=stop) held for cpb cycles.
  function automatic logic [79:0] wave(input logic [9:0] f, input int cpb);
    logic [79:0] w;
    w = '0;
    for (int b = 0; b < 10; b++)
      for (int c = 0; c < cpb; c++)
        w[b*cpb+c] = f[b];
    return w;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Samples tx/busy of the CLKS_PER_BIT=4 instance, starting with the current cycle.
  task automatic capture4(input int n, output logic [79:0] wv, output logic busy_all);
    wv = '0;
    busy_all = 1'b1;
    for (int k = 0; k < n; k++) begin
      wv[k] = tx;
      busy_all = busy_all & busy;
      step();
    end
  endtask

  task automatic run_frame4(input string tag, input logic [7:0] data);
    logic [79:0] wv;
    logic        ba;
    in_valid = 1'b1;
    in_data  = data;
    step();
    in_valid = 1'b0;
    check({tag, "_pre_tx"}, tx, 1'b1);
    check({tag, "_pre_busy"}, busy, 1'b0);
    step();
    capture4(40, wv, ba);
    check({tag, "_wave"}, wv, wave({1'b1, data, 1'b0}, 4));
    check({tag, "_busy_frame"}, ba, 1'b1);
    check({tag, "_busy_after"}, busy, 1'b0);
    check({tag, "_tx_after"}, tx, 1'b1);
  endtask

  initial begin
    logic [79:0] wv;
    logic        ba;
    logic [9:0]  rdy_vec;
    logic        txlog [0:219];
    logic [9:0]  fr;
    logic [7:0]  jb;

    rst = 1'b1;
    step();
    step();
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_drop", drop_cnt, 8'h00);
    check("rst_ready", in_ready, 1'b1);
    check("rst_tx1", tx1, 1'b1);
    rst = 1'b0;
    step();

    // Single byte, latency and full frame shape.
    run_frame4("t1_a5", 8'hA5);

    // Two bytes on consecutive cycles produce contiguous frames.
    in_valid = 1'b1;
    in_data  = 8'h01;
    step();
    in_data  = 8'h02;
    step();
    in_valid = 1'b0;
    capture4(80, wv, ba);
    check("t2_wave", wv, wave({1'b1, 8'h01, 1'b0}, 4) | (wave({1'b1, 8'h02, 1'b0}, 4) << 40));
    check("t2_busy_frames", ba, 1'b1);
    check("t2_busy_after", busy, 1'b0);

    // Ten offers into a depth-4 FIFO: five accepted, five dropped.
    rdy_vec = '0;
    for (int c = 0; c < 220; c++) begin
      in_valid = (c < 10);
      in_data  = 8'(c);
      step();
      if (c < 10) rdy_vec[c] = in_ready;
      txlog[c] = tx;
    end
    in_valid = 1'b0;
    check("t3_ready_seq", rdy_vec, 10'b00_0000_1111);
    check("t3_drop_cnt", drop_cnt, 8'd5);
    for (int j = 0; j < 5; j++) begin
      for (int b = 0; b < 10; b++) fr[b] = txlog[1 + 40*j + 4*b + 2];
      jb = 8'(j);
      check($sformatf("t3_frame%0d", j), fr, {1'b1, jb, 1'b0});
    end

    // Long overflow saturates the drop counter.
    in_valid = 1'b1;
    in_data  = 8'h77;
    for (int c = 0; c < 300; c++) step();
    in_valid = 1'b0;
    check("t4_drop_sat", drop_cnt, 8'hFF);

    // Asynchronous reset in the middle of a data bit.
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = (i == 0) ? 8'h3C : 8'(8'h11 * i);
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("t5_pre_tx", tx, 1'b0);
    check("t5_pre_busy", busy, 1'b1);
    check("t5_pre_drop", drop_cnt, 8'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_tx", tx, 1'b1);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_drop", drop_cnt, 8'h00);
    check("t5_rst_ready", in_ready, 1'b1);
    step();
    rst = 1'b0;
    step();
    run_frame4("t5_c3", 8'hC3);

    // One clock per bit.
    v1 = 1'b1;
    d1 = 8'h80;
    step();
    v1 = 1'b0;
    step();
    wv = '0;
    ba = 1'b1;
    for (int k = 0; k < 10; k++) begin
      wv[k] = tx1;
      ba = ba & busy1;
      step();
    end
    check("t6_wave", wv, 80'b11_0000_0000);
    check("t6_busy_frame", ba, 1'b1);
    check("t6_busy_after", busy1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
